instr_fetch: RTL and testbench

- Instruction-fetch initiator on the instruction-memory read port: drives word address and read enable, captures returned words, and buffers them for the decoder.
- The ROM samples `re`/`addr` on the falling edge and presents `rd` before the next rising edge. A request issued in cycle N is therefore captured at the posedge ending cycle N.
- Provides a valid/ready stream of {pc, instr} to decode, with redirect (branch/jump/trap) flush and misaligned-target fault reporting.

---
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: requests sequential words from a negedge-sampling ROM
// and buffers {pc, instr} pairs for decode, with redirect flush and misalignment fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_re,
  output logic [31:2] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             fault_q, fault_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic             issue;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // A full buffer never issues, even when the head drains in the same cycle.
  assign issue       = !rst && !fault_q && !redirect_valid && (count_q < FULL_CNT);
  assign out_valid   = (count_q != '0) && !redirect_valid;
  assign pop         = out_valid && out_ready;
  assign imem_re     = issue;
  assign imem_addr   = fetch_pc_q[31:2];
  assign out_instr   = instr_mem_q[rd_ptr_q];
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign fetch_fault = fault_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fault_d    = fault_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fault_d    = |redirect_pc[1:0];
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({issue, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fault_q    <= fault_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rd;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a queue-based reference model predicts the buffered
// stream; a negedge monitor compares DUT outputs against it under directed and random stimulus.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_re;
  logic [31:2] imem_addr;
  logic [31:0] imem_rd = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int tests  = 0;
  int failed = 0;

  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  bit          do_issue;
  bit          do_pop;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_re        (imem_re),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] word_addr);
    return {2'b00, word_addr} + 32'h100;
  endfunction

  // ROM: samples request on the falling edge, data valid before the next rising edge.
  always @(negedge clk) imem_rd <= imem_re ? rom(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the expected buffer contents in program order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc    = {redirect_pc[31:2], 2'b00};
      m_fault = (redirect_pc[1:0] != 2'b00);
    end else begin
      do_issue = !m_fault && (exp_q.size() < DEPTH);
      do_pop   = (exp_q.size() != 0) && out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (do_issue) begin
        exp_q.push_back('{pc: m_pc, instr: rom(m_pc[31:2])});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: compares every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_re;
    exp_valid = !rst && (exp_q.size() != 0) && !redirect_valid;
    exp_re    = !rst && !m_fault && !redirect_valid && (exp_q.size() < DEPTH);
    check("out_valid",   32'(out_valid),   32'(exp_valid));
    check("imem_re",     32'(imem_re),     32'(exp_re));
    check("imem_addr",   32'(imem_addr),   32'(m_pc[31:2]));
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (exp_valid) begin
      check("out_pc",    out_pc,    exp_q[0].pc);
      check("out_instr", out_instr, exp_q[0].instr);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycles(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] tmp;
    int          r;

    // Sequential fetch from reset.
    cycles(3);
    rst = 1'b0;
    cycles(20);

    // Backpressure from reset, then release.
    rst       = 1'b1;
    out_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(6);
    out_ready = 1'b1;
    cycles(10);

    // Redirects: aligned, misaligned, recovery, wrap-around.
    redirect(32'h0000_0040);
    cycles(8);
    redirect(32'h0000_0042);
    cycles(5);
    redirect(32'h0000_0080);
    cycles(6);
    redirect(32'hFFFF_FFF8);
    cycles(6);

    // Async reset between edges while the buffer is full.
    out_ready = 1'b0;
    cycles(4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_imem_re",   32'(imem_re),   32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    cycles(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r              = $urandom_range(0, 199);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = (r < 8);
      rst            = (r == 199);
      tmp            = (r < 3) ? (32'hFFFF_FFF0 + {28'h0, 4'($urandom_range(0, 15))}) : $urandom;
      redirect_pc    = {tmp[31:2], ($urandom_range(0, 3) == 0) ? tmp[1:0] : 2'b00};
      cycles(1);
    end
    redirect_valid = 1'b0;
    rst            = 1'b0;
    cycles(4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
